snn_spike_collector: RTL and testbench
======================================

Name: snn_spike_collector

Overview:
- Parametrised output-side collector for the SNN grid wrapper.
- After each tick's processing completes, drains the core's output packet FIFO (neuron indices) and assembles a NUM_OUTPUT-bit spike vector, mapping index i to bit NUM_OUTPUT-1-i.
- Computes a per-class vote (popcount per neuron group) and the winning class.
- Replaces software draining/comparison with a hardware result path, generalised in output count, index width and class count.

Parameters:
- NUM_OUTPUT, 250, number of output neurons / spike vector width
- IDX_W, 8, width of output packet (neuron index)
- NUM_CLASSES, 10, vote groups; NUM_OUTPUT must be a multiple of NUM_CLASSES; group size G = NUM_OUTPUT/NUM_CLASSES
- CLS_W, $clog2(NUM_CLASSES), winner index width
- CNT_W, $clog2(G+1), vote count width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- frame_done  in  1  one-cycle pulse: core finished the current tick; start drain
- fifo_rdata  in  IDX_W  head of output FIFO (first-word-fall-through, valid while !fifo_rempty)
- fifo_rempty  in  1  output FIFO empty
- fifo_rinc  out  1  pop FIFO head this cycle
- busy  out  1  FSM not in IDLE
- result_valid  out  1  one-cycle pulse: results below updated
- spike_vec  out  NUM_OUTPUT  latched spike vector of last frame
- winner  out  CLS_W  class with highest vote
- winner_count  out  CNT_W  vote count of winner
- frame_count  out  16  completed frames, wraps at 65535->0
- idx_error  out  1  sticky: index >= NUM_OUTPUT received
- overrun  out  1  sticky: frame_done arrived while busy

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; all outputs and the working vector reset to 0.
- IDLE: fifo_rinc=0; FIFO is never read. frame_done -> DRAIN next cycle.
- DRAIN: fifo_rinc = !fifo_rempty (combinational, one pop per cycle, back-to-back allowed).
  - On each pop with idx < NUM_OUTPUT: set work[NUM_OUTPUT-1-idx]. Duplicate indices leave the bit at 1.
  - idx >= NUM_OUTPUT: entry popped and dropped; idx_error<=1.
  - fifo_rempty=1 in DRAIN -> VOTE. An empty FIFO at entry gives a zero vector after 1 DRAIN cycle.
- VOTE: one class per cycle, c = 0..NUM_CLASSES-1.
  - Class c owns indices [c*G, (c+1)*G-1], i.e. work bits NUM_OUTPUT-1-c*G down to NUM_OUTPUT-G-c*G.
  - Popcount the group. Replace the running best only if strictly greater, so ties go to the lowest class and all-zero gives winner=0, count=0.
  - After class NUM_CLASSES-1 -> DONE.
- DONE, single cycle:
  - Latch spike_vec<=work, winner, winner_count.
  - result_valid=1; frame_count++; work<=0.
  - -> IDLE.
- Latency from frame_done to result_valid = 1 + N_pop + 1 (empty detect) + NUM_CLASSES + 1 cycles; for N_pop=0, NUM_CLASSES=10: 13 cycles.
- frame_done while busy: ignored, overrun<=1; the current frame is unaffected.
- Sticky flags clear only on reset.
- Outputs hold between result_valid pulses.
- Reset mid-DRAIN/VOTE: partial frame discarded; frame_count stays 0.

Optional Feature:
- Macro SPIKE_GOLDEN_CMP_EN. When defined, adds these ports:
  - golden_vec  in  NUM_OUTPUT  expected vector, sampled in DONE
  - match  out  1  valid with result_valid: work==golden_vec
  - mismatch_count  out  16  saturating count of mismatched frames
- match and mismatch_count reset to 0.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then frame_done with FIFO holding {0,1,249} -> 3 pops on consecutive cycles; spike_vec bits 249,248,0 set; winner=0, winner_count=2; result_valid pulse; frame_count=1.
- Push indices 25..49 (all of class 1) plus 0 -> winner=1, winner_count=25; ties test: indices {0,25} -> winner=0, count=1.
- Empty FIFO at frame_done -> spike_vec=0, winner=0, result_valid exactly 13 cycles after frame_done, fifo_rinc never asserted.
- Index 250 and duplicate 7,7 -> 250 popped and dropped, idx_error=1; only bit 242 set.
- frame_done pulsed again during DRAIN -> overrun=1, single result_valid; then assert reset_n=0 mid-VOTE -> all outputs 0, FSM IDLE.
- With SPIKE_GOLDEN_CMP_EN: golden_vec equal then differing by one bit over two frames -> match=1 then 0; mismatch_count=1.

Source files
------------

// File: rtl/snn_spike_collector_if.sv
// FIFO read port between the spike collector and the core's output packet FIFO.
// The FIFO is first-word-fall-through: fifo_rdata is the head while !fifo_rempty.
interface snn_spike_collector_if #(
  parameter int IDX_W = 8
);
  logic [IDX_W-1:0] fifo_rdata;
  logic             fifo_rempty;
  logic             fifo_rinc;

  modport master (input fifo_rdata, input fifo_rempty, output fifo_rinc);
  modport slave  (output fifo_rdata, output fifo_rempty, input fifo_rinc);
endinterface

// File: rtl/snn_spike_collector.sv
// Output-side spike collector for the SNN grid wrapper.
// After each tick it drains the output FIFO into a spike vector (index i -> bit
// NUM_OUTPUT-1-i), popcounts each class group and reports the winning class.
// Optional golden-vector comparison is enabled with macro SPIKE_GOLDEN_CMP_EN.
module snn_spike_collector #(
  parameter int NUM_OUTPUT  = 250,
  parameter int IDX_W       = 8,
  parameter int NUM_CLASSES = 10,
  parameter int CLS_W       = $clog2(NUM_CLASSES),
  parameter int CNT_W       = $clog2(NUM_OUTPUT / NUM_CLASSES + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  snn_spike_collector_if.master    fifo_if,
  input  logic                     frame_done,
  output logic                     busy,
  output logic                     result_valid,
  output logic [NUM_OUTPUT-1:0]    spike_vec,
  output logic [CLS_W-1:0]         winner,
  output logic [CNT_W-1:0]         winner_count,
  output logic [15:0]              frame_count,
  output logic                     idx_error,
  output logic                     overrun
`ifdef SPIKE_GOLDEN_CMP_EN
  ,
  input  logic [NUM_OUTPUT-1:0]    golden_vec,
  output logic                     match,
  output logic [15:0]              mismatch_count
`endif
);

  localparam int G = NUM_OUTPUT / NUM_CLASSES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    VOTE  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_OUTPUT-1:0] work_q, work_d;
  logic [CLS_W-1:0]      cls_q, cls_d;
  logic [CLS_W-1:0]      best_cls_q, best_cls_d;
  logic [CNT_W-1:0]      best_cnt_q, best_cnt_d;
  logic [NUM_OUTPUT-1:0] spike_vec_q, spike_vec_d;
  logic [CLS_W-1:0]      winner_q, winner_d;
  logic [CNT_W-1:0]      winner_count_q, winner_count_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  idx_error_q, idx_error_d;
  logic                  overrun_q, overrun_d;
  logic                  result_valid_q, result_valid_d;
`ifdef SPIKE_GOLDEN_CMP_EN
  logic                  match_q, match_d;
  logic [15:0]           mismatch_count_q, mismatch_count_d;
`endif

  logic [NUM_OUTPUT-1:0] grp_sh;
  logic [CNT_W-1:0]      grp_cnt;
  logic [IDX_W-1:0]      idx;

  assign idx               = fifo_if.fifo_rdata;
  assign fifo_if.fifo_rinc = (state_q == DRAIN) && !fifo_if.fifo_rempty;

  // Popcount of the current class group: shift the group to the top, sum its G bits
  always_comb begin
    grp_sh  = work_q << (int'(cls_q) * G);
    grp_cnt = '0;
    for (int i = 0; i < G; i++) begin
      grp_cnt = grp_cnt + CNT_W'(grp_sh[NUM_OUTPUT-1-i]);
    end
  end

  // Next-state and datapath updates for IDLE -> DRAIN -> VOTE -> DONE
  always_comb begin
    state_d        = state_q;
    work_d         = work_q;
    cls_d          = cls_q;
    best_cls_d     = best_cls_q;
    best_cnt_d     = best_cnt_q;
    spike_vec_d    = spike_vec_q;
    winner_d       = winner_q;
    winner_count_d = winner_count_q;
    frame_count_d  = frame_count_q;
    idx_error_d    = idx_error_q;
    overrun_d      = overrun_q;
    result_valid_d = 1'b0;
`ifdef SPIKE_GOLDEN_CMP_EN
    match_d          = match_q;
    mismatch_count_d = mismatch_count_q;
`endif

    // A new tick while still working on the previous one is dropped and flagged
    if (frame_done && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_done) state_d = DRAIN;
      end
      DRAIN: begin
        cls_d      = '0;
        best_cls_d = '0;
        best_cnt_d = '0;
        if (fifo_if.fifo_rempty) begin
          state_d = VOTE;
        end else if (int'(idx) < NUM_OUTPUT) begin
          for (int i = 0; i < NUM_OUTPUT; i++) begin
            if (int'(idx) == i) work_d[NUM_OUTPUT-1-i] = 1'b1;
          end
        end else begin
          idx_error_d = 1'b1;
        end
      end
      VOTE: begin
        // Strictly greater: ties keep the lower class, all-zero keeps class 0
        if (grp_cnt > best_cnt_q) begin
          best_cnt_d = grp_cnt;
          best_cls_d = cls_q;
        end
        if (cls_q == CLS_W'(NUM_CLASSES - 1)) state_d = DONE;
        else                                  cls_d   = cls_q + 1'b1;
      end
      DONE: begin
        spike_vec_d    = work_q;
        winner_d       = best_cls_q;
        winner_count_d = best_cnt_q;
        frame_count_d  = frame_count_q + 16'd1;
        result_valid_d = 1'b1;
        work_d         = '0;
`ifdef SPIKE_GOLDEN_CMP_EN
        match_d = (work_q == golden_vec);
        if ((work_q != golden_vec) && (mismatch_count_q != 16'hFFFF))
          mismatch_count_d = mismatch_count_q + 16'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any partial frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      work_q         <= '0;
      cls_q          <= '0;
      best_cls_q     <= '0;
      best_cnt_q     <= '0;
      spike_vec_q    <= '0;
      winner_q       <= '0;
      winner_count_q <= '0;
      frame_count_q  <= '0;
      idx_error_q    <= 1'b0;
      overrun_q      <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef SPIKE_GOLDEN_CMP_EN
      match_q          <= 1'b0;
      mismatch_count_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      work_q         <= work_d;
      cls_q          <= cls_d;
      best_cls_q     <= best_cls_d;
      best_cnt_q     <= best_cnt_d;
      spike_vec_q    <= spike_vec_d;
      winner_q       <= winner_d;
      winner_count_q <= winner_count_d;
      frame_count_q  <= frame_count_d;
      idx_error_q    <= idx_error_d;
      overrun_q      <= overrun_d;
      result_valid_q <= result_valid_d;
`ifdef SPIKE_GOLDEN_CMP_EN
      match_q          <= match_d;
      mismatch_count_q <= mismatch_count_d;
`endif
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = result_valid_q;
  assign spike_vec    = spike_vec_q;
  assign winner       = winner_q;
  assign winner_count = winner_count_q;
  assign frame_count  = frame_count_q;
  assign idx_error    = idx_error_q;
  assign overrun      = overrun_q;
`ifdef SPIKE_GOLDEN_CMP_EN
  assign match          = match_q;
  assign mismatch_count = mismatch_count_q;
`endif

endmodule

// File: tb/tb_snn_spike_collector.sv
// Bench for snn_spike_collector: FIFO model, behavioural class-vote model,
// directed scenarios plus randomized frames.
module tb_snn_spike_collector;
  localparam int NO = 250;
  localparam int NC = 10;
  localparam int G  = NO / NC;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_done = 1'b0;
  logic          busy, result_valid, idx_error, overrun;
  logic [NO-1:0] spike_vec;
  logic [3:0]    winner;
  logic [4:0]    winner_count;
  logic [15:0]   frame_count;
`ifdef SPIKE_GOLDEN_CMP_EN
  logic [NO-1:0] golden_vec = '0;
  logic          match;
  logic [15:0]   mismatch_count;
`endif

  snn_spike_collector_if #(.IDX_W(8)) ff ();

  snn_spike_collector #(.NUM_OUTPUT(NO), .IDX_W(8), .NUM_CLASSES(NC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_if      (ff),
    .frame_done   (frame_done),
    .busy         (busy),
    .result_valid (result_valid),
    .spike_vec    (spike_vec),
    .winner       (winner),
    .winner_count (winner_count),
    .frame_count  (frame_count),
    .idx_error    (idx_error),
    .overrun      (overrun)
`ifdef SPIKE_GOLDEN_CMP_EN
    ,
    .golden_vec     (golden_vec),
    .match          (match),
    .mismatch_count (mismatch_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: tasks write fifo_mem/wr_ptr, this block owns rd_ptr and the pops
  logic [7:0] fifo_mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         pop_cnt = 0;
  bit         pop_pend = 1'b0;

  always @(negedge clk) begin
    if (pop_pend) begin
      rd_ptr  = rd_ptr + 1;
      pop_cnt = pop_cnt + 1;
    end
    ff.fifo_rdata  = fifo_mem[rd_ptr];
    ff.fifo_rempty = (rd_ptr == wr_ptr);
    #1 pop_pend = (ff.fifo_rinc === 1'b1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int            stim [$];
  logic [NO-1:0] exp_vec;
  int            exp_win, exp_cnt, exp_frames;
  bit            exp_idx_err;

  function automatic void model_frame();
    int  cnt [NC];
    bit  seen [NO];
    int  best;
    exp_vec = '0;
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    for (int i = 0; i < NO; i++) seen[i] = 1'b0;
    foreach (stim[k]) begin
      if (stim[k] >= NO) exp_idx_err = 1'b1;
      else begin
        exp_vec[NO-1-stim[k]] = 1'b1;
        if (!seen[stim[k]]) begin
          seen[stim[k]] = 1'b1;
          cnt[stim[k] / G]++;
        end
      end
    end
    exp_win = 0;
    best    = 0;
    for (int c = 0; c < NC; c++) if (cnt[c] > best) begin best = cnt[c]; exp_win = c; end
    exp_cnt    = best;
    exp_frames = (exp_frames + 1) % 65536;
  endfunction

  task automatic push_stim();
    foreach (stim[k]) begin
      fifo_mem[wr_ptr] = 8'(stim[k]);
      wr_ptr++;
    end
  endtask

  // Loads the FIFO, pulses frame_done and returns the cycles until result_valid (-1 on timeout)
  task automatic run_frame(output int lat);
    push_stim();
    @(negedge clk);
    @(negedge clk);
    frame_done = 1'b1;
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      frame_done = 1'b0;
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({spike_vec, winner, winner_count, frame_count} !== '0)
      $display("FAIL reset_results: got vec=%h win=%0d cnt=%0d frames=%0d want all 0", spike_vec, winner, winner_count, frame_count);
    else n_pass++;
    n_checks++;
    if ({busy, result_valid, idx_error, overrun, ff.fifo_rinc} !== 5'b0)
      $display("FAIL reset_ctrl: got busy/rv/ierr/ovr/rinc=%b want 00000", {busy, result_valid, idx_error, overrun, ff.fifo_rinc});
    else n_pass++;
    reset_n = 1'b1;
    exp_frames = 0; exp_idx_err = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat, p0;
    stim = '{0, 1, 249};
    model_frame();
    p0 = pop_cnt;
    run_frame(lat);
    n_checks++;
    if (lat != 16) $display("FAIL basic_latency: got %0d want 16", lat); else n_pass++;
    n_checks++;
    if (spike_vec !== exp_vec) $display("FAIL basic_vec: got %h want %h", spike_vec, exp_vec); else n_pass++;
    n_checks++;
    if (winner !== 4'(exp_win) || winner_count !== 5'(exp_cnt))
      $display("FAIL basic_winner: got %0d/%0d want %0d/%0d", winner, winner_count, exp_win, exp_cnt);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'(exp_frames)) $display("FAIL basic_frames: got %0d want %0d", frame_count, exp_frames); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0 || pop_cnt - p0 != 3)
      $display("FAIL basic_pulse_pops: got rv=%b pops=%0d want rv=0 pops=3", result_valid, pop_cnt - p0);
    else n_pass++;
  endtask

  task automatic test_class_vote();
    int lat;
    stim = {};
    for (int i = 25; i <= 49; i++) stim.push_back(i);
    stim.push_back(0);
    model_frame();
    run_frame(lat);
    n_checks++;
    if (winner !== 4'd1 || winner_count !== 5'd25 || spike_vec !== exp_vec)
      $display("FAIL class1_vote: got %0d/%0d want 1/25", winner, winner_count);
    else n_pass++;
    stim = '{25, 0};
    model_frame();
    run_frame(lat);
    n_checks++;
    if (winner !== 4'd0 || winner_count !== 5'd1 || lat != 15)
      $display("FAIL tie_vote: got %0d/%0d lat %0d want 0/1 lat 15", winner, winner_count, lat);
    else n_pass++;
  endtask

  task automatic test_empty();
    int lat, p0;
    stim = {};
    model_frame();
    p0 = pop_cnt;
    run_frame(lat);
    n_checks++;
    if (lat != 13) $display("FAIL empty_latency: got %0d want 13", lat); else n_pass++;
    n_checks++;
    if (spike_vec !== '0 || winner !== 4'd0 || winner_count !== 5'd0 || pop_cnt != p0)
      $display("FAIL empty_result: got vec=%h win=%0d pops=%0d want 0/0/0", spike_vec, winner, pop_cnt - p0);
    else n_pass++;
  endtask

  task automatic test_idx_error();
    int lat, p0;
    logic [NO-1:0] want;
    want = '0;
    want[242] = 1'b1;
    stim = '{250, 7, 7};
    model_frame();
    p0 = pop_cnt;
    run_frame(lat);
    n_checks++;
    if (idx_error !== 1'b1) $display("FAIL idx_error_flag: got %b want 1", idx_error); else n_pass++;
    n_checks++;
    if (spike_vec !== want || pop_cnt - p0 != 3)
      $display("FAIL idx_error_vec: got %h pops=%0d want %h pops=3", spike_vec, pop_cnt - p0, want);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, n, hot;
    for (int f = 0; f < 10; f++) begin
      stim = {};
      n = $urandom_range(0, 40);
      hot = $urandom_range(0, NC - 1);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 11))
          0:       stim.push_back($urandom_range(250, 255));
          1, 2, 3: stim.push_back(hot * G + $urandom_range(0, G - 1));
          default: stim.push_back($urandom_range(0, NO - 1));
        endcase
      end
      model_frame();
      run_frame(lat);
      n_checks++;
      if (lat != n + 13 || spike_vec !== exp_vec)
        $display("FAIL rand%0d_vec: got lat=%0d vec=%h want lat=%0d vec=%h", f, lat, spike_vec, n + 13, exp_vec);
      else n_pass++;
      n_checks++;
      if (winner !== 4'(exp_win) || winner_count !== 5'(exp_cnt) || frame_count !== 16'(exp_frames))
        $display("FAIL rand%0d_vote: got %0d/%0d fc=%0d want %0d/%0d fc=%0d", f, winner, winner_count, frame_count, exp_win, exp_cnt, exp_frames);
      else n_pass++;
      n_checks++;
      if (idx_error !== exp_idx_err || overrun !== 1'b0 || rd_ptr != wr_ptr)
        $display("FAIL rand%0d_flags: got ierr=%b ovr=%b left=%0d want ierr=%b ovr=0 left=0", f, idx_error, overrun, wr_ptr - rd_ptr, exp_idx_err);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    int rv_seen;
    stim = '{10, 60, 61, 120, 200};
    model_frame();
    push_stim();
    @(negedge clk);
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    @(negedge clk);
    frame_done = 1'b1;
    rv_seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      frame_done = 1'b0;
      if (result_valid === 1'b1) rv_seen++;
    end
    n_checks++;
    if (overrun !== 1'b1 || rv_seen != 1)
      $display("FAIL overrun: got ovr=%b pulses=%0d want ovr=1 pulses=1", overrun, rv_seen);
    else n_pass++;
    n_checks++;
    if (spike_vec !== exp_vec || frame_count !== 16'(exp_frames))
      $display("FAIL overrun_frame: got vec=%h fc=%0d want vec=%h fc=%0d", spike_vec, frame_count, exp_vec, exp_frames);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    stim = '{5, 30, 31};
    push_stim();
    @(negedge clk);
    @(negedge clk);
    frame_done = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      frame_done = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1) $display("FAIL mid_vote_busy: got %b want 1", busy); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({spike_vec, winner, winner_count, frame_count, idx_error, overrun, busy, result_valid} !== '0)
      $display("FAIL reset_mid_vote: got fc=%0d busy=%b ovr=%b want all 0", frame_count, busy, overrun);
    else n_pass++;
    exp_frames = 0; exp_idx_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || frame_count !== 16'd0 || result_valid !== 1'b0)
      $display("FAIL reset_mid_after: got busy=%b fc=%0d rv=%b want 0/0/0", busy, frame_count, result_valid);
    else n_pass++;
    stim = '{77};
    model_frame();
    run_frame(lat);
    n_checks++;
    if (frame_count !== 16'd1 || spike_vec !== exp_vec || lat != 14)
      $display("FAIL reset_mid_recover: got fc=%0d lat=%0d want fc=1 lat=14", frame_count, lat);
    else n_pass++;
  endtask

`ifdef SPIKE_GOLDEN_CMP_EN
  task automatic test_golden();
    int lat;
    stim = '{3, 100, 200};
    model_frame();
    golden_vec = exp_vec;
    run_frame(lat);
    n_checks++;
    if (match !== 1'b1 || mismatch_count !== 16'd0)
      $display("FAIL golden_equal: got match=%b mc=%0d want 1/0", match, mismatch_count);
    else n_pass++;
    model_frame();
    golden_vec = exp_vec;
    golden_vec[17] = ~golden_vec[17];
    run_frame(lat);
    n_checks++;
    if (match !== 1'b0 || mismatch_count !== 16'd1)
      $display("FAIL golden_differ: got match=%b mc=%0d want 0/1", match, mismatch_count);
    else n_pass++;
  endtask
`endif

  initial begin
    exp_frames = 0;
    exp_idx_err = 1'b0;
    test_reset();
    test_basic();
    test_class_vote();
    test_empty();
    test_random();
    test_idx_error();
    test_overrun();
    test_reset_mid();
`ifdef SPIKE_GOLDEN_CMP_EN
    test_golden();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
